// File: rtl/mac_fifo_chk_ctrl.sv
// mac_fifo_chk_ctrl: run sequencer for the MAC TX/RX data-compare FIFO checker.
// Build option MAC_CHK_CTRL_WATCHDOG_EN adds a RUN-state stall watchdog (fail_code[5]).
module mac_fifo_chk_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int DRAIN_CYCLES  = 256,
    parameter int CNT_W         = 32
) (
    input  logic             axi_aclk,
    input  logic             axi_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_words,
    input  logic [31:0]      fifo_rd_err_count,
    input  logic [CNT_W-1:0] fifo_tx_wr_count,
    input  logic [CNT_W-1:0] fifo_rx_wr_count,
    input  logic             fifo_tx_err_overflow,
    input  logic             fifo_tx_err_underflow,
    input  logic             fifo_rx_err_overflow,
    input  logic             fifo_rx_err_underflow,
    output logic             fifo_rst,
    output logic             fifo_rst_status,
    output logic             gen_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       fail_code,
    output logic [2:0]       state
);
    localparam int MAXC = (RST_CYCLES > SETTLE_CYCLES)
        ? ((RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES)
        : ((SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES);
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RST = 3'd1, S_CLR = 3'd2, S_SETTLE = 3'd3,
        S_RUN = 3'd4, S_DRAIN = 3'd5, S_CHECK = 3'd6, S_DONE = 3'd7
    } st_t;

    st_t              st;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] run_lat;
    logic [5:0]       grade;
    logic             wd;

`ifdef MAC_CHK_CTRL_WATCHDOG_EN
    logic [15:0]      stall;
    logic [CNT_W-1:0] prev_tx;

    // previous TX count, so RUN can see whether the source is still making progress
    always_ff @(posedge axi_aclk) begin
        prev_tx <= axi_rst ? '0 : fifo_tx_wr_count;
    end
`else
    assign wd = 1'b0;
`endif

    assign state = st;
    assign grade = {wd, 1'b0, fifo_tx_wr_count != fifo_rx_wr_count,
                    fifo_tx_err_underflow | fifo_rx_err_underflow,
                    fifo_tx_err_overflow | fifo_rx_err_overflow,
                    fifo_rd_err_count != 32'd0};

    // sequencer: every output is registered and changes on the edge entering its state
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            st              <= S_IDLE;
            cnt             <= '0;
            run_lat         <= '0;
            fifo_rst        <= 1'b0;
            fifo_rst_status <= 1'b0;
            gen_en          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_code       <= '0;
`ifdef MAC_CHK_CTRL_WATCHDOG_EN
            stall           <= '0;
            wd              <= 1'b0;
`endif
        end else if (abort && busy) begin
            st              <= S_DONE;
            fifo_rst        <= 1'b0;
            fifo_rst_status <= 1'b0;
            gen_en          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b1;
            pass            <= 1'b0;
            fail_code       <= 6'h10;
        end else begin
            case (st)
                S_IDLE, S_DONE: if (start) begin
                    st        <= S_RST;
                    run_lat   <= run_words;
                    cnt       <= CW'(RST_CYCLES - 1);
                    fifo_rst  <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    fail_code <= '0;
`ifdef MAC_CHK_CTRL_WATCHDOG_EN
                    wd        <= 1'b0;
`endif
                end
                S_RST: if (cnt == '0) begin
                    st              <= S_CLR;
                    fifo_rst        <= 1'b0;
                    fifo_rst_status <= 1'b1;
                end else cnt <= cnt - 1'b1;
                S_CLR: begin
                    st              <= S_SETTLE;
                    fifo_rst_status <= 1'b0;
                    cnt             <= CW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                else if (run_lat == '0) begin
                    st  <= S_DRAIN;
                    cnt <= CW'(DRAIN_CYCLES - 1);
                end else begin
                    st     <= S_RUN;
                    gen_en <= 1'b1;
`ifdef MAC_CHK_CTRL_WATCHDOG_EN
                    stall  <= '0;
`endif
                end
                S_RUN: if (fifo_tx_wr_count >= run_lat) begin
                    st     <= S_DRAIN;
                    gen_en <= 1'b0;
                    cnt    <= CW'(DRAIN_CYCLES - 1);
                end
`ifdef MAC_CHK_CTRL_WATCHDOG_EN
                else if (stall == 16'hFFFF) begin
                    st     <= S_DRAIN;
                    gen_en <= 1'b0;
                    cnt    <= CW'(DRAIN_CYCLES - 1);
                    wd     <= 1'b1;
                end else stall <= (fifo_tx_wr_count != prev_tx) ? '0 : stall + 1'b1;
`endif
                S_DRAIN: if (cnt == '0) st <= S_CHECK;
                else cnt <= cnt - 1'b1;
                S_CHECK: begin
                    st        <= S_DONE;
                    fail_code <= grade;
                    pass      <= grade == 6'h00;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_fifo_chk_ctrl.sv
// tb_mac_fifo_chk_ctrl: table-driven and randomized self-checking bench for mac_fifo_chk_ctrl.
module tb_mac_fifo_chk_ctrl;
    logic        axi_aclk, axi_rst, start, abort;
    logic [31:0] run_words, fifo_rd_err_count, fifo_tx_wr_count, fifo_rx_wr_count;
    logic        tov, tun, rov, run_;
    logic        fifo_rst, fifo_rst_status, gen_en, busy, done, pass;
    logic [5:0]  fail_code;
    logic [2:0]  state;
    logic [31:0] tx_cnt, tx_init;
    logic        clr_tx, freeze;
    int          rx_delta;
    int          n_tests, n_fail;

    typedef struct {
        int         n;
        int         rd;
        int         dl;
        logic       tov, rov, tun, run_;
        logic [5:0] fc;
    } vec_t;
    vec_t tbl[6];

    mac_fifo_chk_ctrl dut (
        .axi_aclk(axi_aclk), .axi_rst(axi_rst), .start(start), .abort(abort),
        .run_words(run_words), .fifo_rd_err_count(fifo_rd_err_count),
        .fifo_tx_wr_count(fifo_tx_wr_count), .fifo_rx_wr_count(fifo_rx_wr_count),
        .fifo_tx_err_overflow(tov), .fifo_tx_err_underflow(tun),
        .fifo_rx_err_overflow(rov), .fifo_rx_err_underflow(run_),
        .fifo_rst(fifo_rst), .fifo_rst_status(fifo_rst_status), .gen_en(gen_en),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .state(state)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    // traffic source model: one TX word per cycle while gen_en is high
    always @(negedge axi_aclk) begin
        if (clr_tx) tx_cnt = tx_init;
        else if (gen_en && !freeze) tx_cnt = tx_cnt + 32'd1;
    end
    assign fifo_tx_wr_count = tx_cnt;
    assign fifo_rx_wr_count = tx_cnt + 32'(rx_delta);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected grade straight from the fail-cause definitions
    function automatic logic [5:0] model(input vec_t v);
        return {1'b0, 1'b0, v.dl != 0, v.tun | v.run_, v.tov | v.rov, v.rd != 0};
    endfunction

    task automatic preset_tx(input logic [31:0] v, input logic frz);
        tx_init = v;
        freeze  = frz;
        clr_tx  = 1'b1;
        repeat (2) @(negedge axi_aclk);
        clr_tx  = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge axi_aclk);
        run_words = 32'(n);
        start = 1'b1;
        @(negedge axi_aclk);
        start = 1'b0;
    endtask

    // full run: measures each phase length and grades the result
    task automatic do_run(input vec_t v);
        int n_rst, n_clr, n_set, n_gen, n_dr, n_ck, n_bb;
        fifo_rd_err_count = 32'(v.rd);
        rx_delta = v.dl;
        {tov, rov, tun, run_} = {v.tov, v.rov, v.tun, v.run_};
        preset_tx(32'd0, 1'b0);
        pulse_start(v.n);
        {n_rst, n_clr, n_set, n_gen, n_dr, n_ck, n_bb} = '0;
        for (int i = 0; i < 3000 && !done; i++) begin
            n_rst += int'(fifo_rst);
            n_clr += int'(fifo_rst_status);
            n_set += int'(state == 3'd3);
            n_gen += int'(gen_en);
            n_dr  += int'(state == 3'd5);
            n_ck  += int'(state == 3'd6);
            n_bb  += int'(busy != (state != 3'd0 && state != 3'd7));
            @(negedge axi_aclk);
        end
        chk("run_done", 32'(done), 32'd1);
        chk("rst_len", 32'(n_rst), 32'd16);
        chk("clr_len", 32'(n_clr), 32'd1);
        chk("settle_len", 32'(n_set), 32'd64);
        chk("gen_len", 32'(n_gen), 32'(v.n));
        chk("drain_len", 32'(n_dr), 32'd256);
        chk("check_len", 32'(n_ck), 32'd1);
        chk("busy_vs_state", 32'(n_bb), 32'd0);
        chk("tx_final", tx_cnt, 32'(v.n));
        chk("fail_code", 32'(fail_code), 32'(v.fc));
        chk("pass", 32'(pass), 32'(v.fc == 6'h00));
        repeat (5) @(negedge axi_aclk);
        chk("hold", 32'({done, pass, fail_code, state}), 32'({1'b1, v.fc == 6'h00, v.fc, 3'd7}));
    endtask

    task automatic wait_gen(input int lim);
        for (int i = 0; i < lim && !gen_en; i++) @(negedge axi_aclk);
        chk("gen_en_seen", 32'(gen_en), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   n;
        logic seen;
        n_tests = 0; n_fail = 0;
        axi_rst = 1'b1; start = 1'b0; abort = 1'b0; run_words = '0;
        fifo_rd_err_count = '0; rx_delta = 0; {tov, rov, tun, run_} = '0;
        tx_init = '0; freeze = 1'b0; clr_tx = 1'b1;
        repeat (3) @(negedge axi_aclk);
        chk("reset_outs", 32'({fifo_rst, fifo_rst_status, gen_en, busy, done, pass, fail_code, state}), 32'd0);
        axi_rst = 1'b0; clr_tx = 1'b0;
        @(negedge axi_aclk);
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        chk("abort_idle_ignored", 32'({done, busy, state}), 32'd0);

        tbl[0] = '{100, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        tbl[1] = '{100, 3, -1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h09};
        tbl[2] = '{0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};
        tbl[3] = '{7,   0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h02};
        tbl[4] = '{1,   0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0C};
        tbl[5] = '{20,  1,  0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h07};
        for (int i = 0; i < 6; i++) do_run(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            v.n   = int'($urandom_range(0, 120));
            v.rd  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
            v.dl  = int'($urandom_range(0, 2)) - 1;
            v.tov = $urandom_range(0, 3) == 0;
            v.rov = $urandom_range(0, 3) == 0;
            v.tun = $urandom_range(0, 3) == 0;
            v.run_ = $urandom_range(0, 3) == 0;
            v.fc  = model(v);
            do_run(v);
        end

        fifo_rd_err_count = '0; rx_delta = 0; {tov, rov, tun, run_} = '0;

        // start+abort together while DONE: start wins
        @(negedge axi_aclk);
        start = 1'b1; abort = 1'b1; run_words = 32'd5;
        @(negedge axi_aclk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_done", 32'({busy, done, fail_code, state}), 32'({1'b1, 1'b0, 6'h00, 3'd1}));
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        chk("abort_in_rst", 32'({fifo_rst, busy, done, pass, fail_code, state}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 3'd7}));

        // start during RST ignored; abort 5 cycles into RUN
        preset_tx(32'd0, 1'b0);
        pulse_start(1000);
        @(negedge axi_aclk);
        start = 1'b1;
        @(negedge axi_aclk);
        start = 1'b0;
        chk("start_in_rst_ignored", 32'({fifo_rst, state}), 32'({1'b1, 3'd1}));
        n = 3;
        for (int i = 0; i < 40 && fifo_rst; i++) begin
            @(negedge axi_aclk);
            n += int'(fifo_rst);
        end
        chk("rst_len_after_restart", 32'(n), 32'd16);
        wait_gen(200);
        repeat (4) @(negedge axi_aclk);
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        chk("abort_run", 32'({gen_en, busy, done, pass, fail_code, state}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 3'd7}));

        // run_words=0, reset while draining
        preset_tx(32'd0, 1'b0);
        pulse_start(0);
        seen = 1'b0;
        for (int i = 0; i < 300 && state != 3'd5; i++) begin
            seen |= gen_en;
            @(negedge axi_aclk);
        end
        chk("reach_drain", 32'(state), 32'd5);
        chk("zero_no_gen", 32'(seen), 32'd0);
        repeat (10) @(negedge axi_aclk);
        axi_rst = 1'b1;
        @(negedge axi_aclk);
        chk("rst_mid_drain", 32'({fifo_rst, fifo_rst_status, gen_en, busy, done, pass, fail_code, state}), 32'd0);
        axi_rst = 1'b0;

        // stalled source: TX count frozen at 10
        preset_tx(32'd10, 1'b1);
        pulse_start(50);
        wait_gen(200);
`ifdef MAC_CHK_CTRL_WATCHDOG_EN
        for (int i = 0; i < 70000 && !done; i++) @(negedge axi_aclk);
        chk("wd_done", 32'({done, pass, fail_code}), 32'({1'b1, 1'b0, 6'h20}));
`else
        repeat (3000) @(negedge axi_aclk);
        chk("stall_stays_run", 32'({gen_en, busy, state}), 32'({1'b1, 1'b1, 3'd4}));
        abort = 1'b1;
        @(negedge axi_aclk);
        abort = 1'b0;
        chk("stall_abort", 32'({done, fail_code}), 32'({1'b1, 6'h10}));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
